// File: rtl/uart_pkg.sv
// uart_pkg: serializer state encoding, 8N1 frame constants and the
// baud divisor helper shared by the UART blocks.
package uart_pkg;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;

    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock show-ahead FIFO with registered occupancy; a write
// is accepted while full when a read frees a slot on the same edge.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   wr_en,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   rd_en,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_level;
    logic             w_rd;
    logic             w_wr;

    assign w_rd    = rd_en && !empty;
    assign w_wr    = wr_en && (!full || w_rd);
    assign full    = r_level == FULL_LVL;
    assign empty   = r_level == '0;
    assign level   = r_level;
    assign rd_data = r_mem[r_rd_ptr];

    always_ff @(posedge clk)
        if (w_wr) r_mem[r_wr_ptr] <= wr_data;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
            r_level <= r_level + {{AW{1'b0}}, w_wr} - {{AW{1'b0}}, w_rd};
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffered 8N1 transmitter; bytes queue in a sync_fifo and are
// shifted out LSB-first on a registered, idle-high line.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 27000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic                        wr_en,
    input  logic [7:0]                  wr_data,
    input  logic                        ovf_clr,
    output logic                        full,
    output logic                        empty,
    output logic [$clog2(FIFO_DEPTH):0] level,
    output logic                        busy,
    output logic                        overflow,
    output logic                        uart_tx
);
    localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    tx_state_t     r_state;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_idx;
    logic [7:0]    r_shift;
    logic          r_tx;
    logic          r_ovf;
    logic [7:0]    w_head;
    logic          w_pop;
    logic          w_bit_end;

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .rd_en   (w_pop),
        .rd_data (w_head),
        .full    (full),
        .empty   (empty),
        .level   (level)
    );

    assign w_pop     = (r_state == TX_IDLE) && !empty;
    assign w_bit_end = r_cnt == LAST_CNT;
    assign busy      = r_state != TX_IDLE;
    assign overflow  = r_ovf;
    assign uart_tx   = r_tx;

    // The line register follows the state one cycle late, so the start bit
    // appears on the edge after the pop.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= TX_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
            r_ovf   <= 1'b0;
        end else begin
            r_tx  <= (r_state == TX_START) ? 1'b0 : (r_state == TX_DATA) ? r_shift[0] : 1'b1;
            r_ovf <= (wr_en && full && !w_pop) ? 1'b1 : ovf_clr ? 1'b0 : r_ovf;
            case (r_state)
                TX_IDLE: if (w_pop) begin
                    r_shift <= w_head;
                    r_cnt   <= '0;
                    r_state <= TX_START;
                end
                TX_START: if (w_bit_end) begin
                    r_cnt   <= '0;
                    r_idx   <= '0;
                    r_state <= TX_DATA;
                end else r_cnt <= r_cnt + 1'b1;
                TX_DATA: if (w_bit_end) begin
                    r_cnt   <= '0;
                    r_shift <= r_shift >> 1;
                    r_idx   <= r_idx + 1'b1;
                    if (r_idx == LAST_BIT) r_state <= TX_STOP;
                end else r_cnt <= r_cnt + 1'b1;
                TX_STOP: if (w_bit_end) begin
                    r_cnt   <= '0;
                    r_state <= TX_IDLE;
                end else r_cnt <= r_cnt + 1'b1;
                default: r_state <= TX_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed bench with a frame-decoding monitor that checks
// transmitted bytes against a scoreboard queue (4 clocks per bit).
module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    logic       resetn;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       ovf_clr;
    logic       full;
    logic       empty;
    logic [4:0] level;
    logic       busy;
    logic       overflow;
    logic       uart_tx;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int frames_done = 0;
    int epoch       = 0;
    logic [7:0] exp_q [$];
    int         starts [$];

    uart_tx_fifo #(.CLK_FREQ(460800), .BAUD(115200), .FIFO_DEPTH(16)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .ovf_clr  (ovf_clr),
        .full     (full),
        .empty    (empty),
        .level    (level),
        .busy     (busy),
        .overflow (overflow),
        .uart_tx  (uart_tx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [7:0] b, input bit push);
        wr_en   = 1'b1;
        wr_data = b;
        if (push) exp_q.push_back(b);
        tick();
    endtask

    task automatic wait_frames(input int n, input int budget);
        int k;
        k = 0;
        while (frames_done < n && k < budget) begin
            tick();
            k++;
        end
        chk("frames_done", frames_done, n);
    endtask

    // Monitor: samples each bit mid-cell and scores the decoded byte.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (resetn === 1'b1 && uart_tx === 1'b0) begin
                int st;
                int ep;
                logic sb;
                logic pb;
                logic [7:0] d;
                logic [7:0] e;
                st = cyc;
                ep = epoch;
                repeat (2) begin @(posedge clk); #2; end
                sb = uart_tx;
                for (int i = 0; i < 8; i++) begin
                    repeat (4) begin @(posedge clk); #2; end
                    d[i] = uart_tx;
                end
                repeat (4) begin @(posedge clk); #2; end
                pb = uart_tx;
                if (ep == epoch) begin
                    starts.push_back(st);
                    frames_done++;
                    vectors++;
                    e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
                    assert (d === e && sb === 1'b0 && pb === 1'b1) else begin
                        miscompares++;
                        $error("FAIL frame: observed %0h start %b stop %b expected %0h start 0 stop 1", d, sb, pb, e);
                    end
                end
            end
        end
    end

    initial begin
        int base;
        int k;
        int bad;
        logic [7:0] b;
        logic expbit;
        resetn  = 1'b0;
        wr_en   = 1'b0;
        wr_data = 8'h00;
        ovf_clr = 1'b0;
        repeat (3) tick();
        chk("rst_tx", uart_tx, 1);
        chk("rst_busy", busy, 0);
        chk("rst_full", full, 0);
        chk("rst_empty", empty, 1);
        chk("rst_level", level, 0);
        chk("rst_ovf", overflow, 0);
        resetn = 1'b1;
        tick();

        // Single frame, cycle-exact line check
        b = 8'hA5;
        wr(b, 1);
        wr_en = 1'b0;
        chk("t1_level_wr", level, 1);
        chk("t1_tx_wr", uart_tx, 1);
        tick();
        chk("t1_tx_pop", uart_tx, 1);
        chk("t1_busy_pop", busy, 1);
        chk("t1_level_pop", level, 0);
        for (int j = 0; j < 40; j++) begin
            tick();
            expbit = (j < 4) ? 1'b0 : (j >= 36) ? 1'b1 : b[j/4 - 1];
            chk("t1_line", uart_tx, expbit);
            chk("t1_busy", busy, (j < 39) ? 1 : 0);
        end
        chk("t1_empty_end", empty, 1);
        tick();
        chk("t1_tx_idle", uart_tx, 1);
        wait_frames(1, 100);

        // Queue three bytes behind a frame in flight
        base = starts.size();
        wr(8'h3C, 1);
        wr_en = 1'b0;
        repeat (3) tick();
        wr(8'h00, 1);
        chk("t2_level1", level, 1);
        wr(8'hFF, 1);
        chk("t2_level2", level, 2);
        wr(8'h55, 1);
        wr_en = 1'b0;
        chk("t2_level3", level, 3);
        k = 0;
        while (level == 3 && k < 100) begin tick(); k++; end
        chk("t2_level_pop", level, 2);
        wait_frames(5, 300);
        for (int j = 1; j < 4; j++)
            chk("t2_spacing", starts[base + j] - starts[base + j - 1], 41);
        repeat (5) tick();
        chk("t2_empty", empty, 1);
        chk("t2_busy", busy, 0);

        // Fill while transmitting, overflow handling
        wr(8'h11, 1);
        wr_en = 1'b0;
        repeat (3) tick();
        for (int j = 0; j < 16; j++) wr(8'h20 + 8'(j), 1);
        wr_en = 1'b0;
        chk("t3_full", full, 1);
        chk("t3_level", level, 16);
        chk("t3_ovf0", overflow, 0);
        wr(8'h99, 0);
        wr_en = 1'b0;
        chk("t3_ovf_set", overflow, 1);
        chk("t3_level_ovf", level, 16);
        ovf_clr = 1'b1;
        wr(8'h98, 0);
        wr_en   = 1'b0;
        ovf_clr = 1'b0;
        chk("t3_ovf_set_wins", overflow, 1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("t3_ovf_clr", overflow, 0);

        // Write while full on the pop edge
        k = 0;
        while (busy && k < 100) begin tick(); k++; end
        chk("t4_idle", busy, 0);
        chk("t4_full_idle", full, 1);
        wr(8'h77, 1);
        wr_en = 1'b0;
        chk("t4_level", level, 16);
        chk("t4_ovf", overflow, 0);
        chk("t4_busy", busy, 1);
        wait_frames(23, 1000);
        repeat (4) tick();
        chk("t4_drained", {empty, busy}, 2'b10);

        // Reset during DATA bit 3 of 0xC3 with 4 bytes queued
        wr(8'hC3, 0);
        for (int j = 0; j < 4; j++) wr(8'hB0 + 8'(j), 0);
        wr_en = 1'b0;
        chk("t5_level", level, 4);
        repeat (13) tick();
        chk("t5_busy_pre", busy, 1);
        resetn = 1'b0;
        epoch++;
        tick();
        resetn = 1'b1;
        chk("t5_tx", uart_tx, 1);
        chk("t5_busy", busy, 0);
        chk("t5_level", level, 0);
        chk("t5_empty", empty, 1);
        bad = 0;
        for (int j = 0; j < 60; j++) begin
            tick();
            if (uart_tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        chk("t5_quiet", bad, 0);
        chk("t5_frames", frames_done, 23);

        // Long reset with wr_en held high
        resetn  = 1'b0;
        wr_en   = 1'b1;
        wr_data = 8'hEE;
        bad = 0;
        for (int j = 0; j < 10; j++) begin
            tick();
            if (level !== 5'd0 || uart_tx !== 1'b1) bad++;
        end
        chk("t6_hold", bad, 0);
        resetn = 1'b1;
        wr_en  = 1'b0;
        tick();
        chk("t6_level", level, 0);
        chk("t6_empty", empty, 1);
        bad = 0;
        for (int j = 0; j < 20; j++) begin
            tick();
            if (uart_tx !== 1'b1) bad++;
        end
        chk("t6_quiet", bad, 0);
        chk("t6_queue", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Buffered 8N1 UART transmitter on the dma block's UART TX path. The dma decodes a store to the UART data register and pulses a one-cycle byte write into this block. Bytes queue in an internal FIFO and are serialized LSB-first onto uartTx. Status outputs let the dma expose "TX full/idle" to software polling loops.

Parameters:
CLK_FREQ, 27000000, system clock frequency in Hz.
BAUD, 115200, line rate. CLKS_PER_BIT = CLK_FREQ/BAUD, truncated (234 at defaults); must be ≥2.
FIFO_DEPTH, 16, byte entries; power of two, ≥2.

Ports:
clk  input  1  system clock (undivided board clock, same as dma).
resetn  input  1  synchronous, active-low reset.
wr_en  input  1  one-cycle byte write strobe from dma.
wr_data  input  8  byte to enqueue; sampled when wr_en=1.
ovf_clr  input  1  clears the sticky overflow flag.
full  output  1  FIFO holds FIFO_DEPTH entries.
empty  output  1  FIFO holds 0 entries.
level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
busy  output  1  serializer not in IDLE.
overflow  output  1  sticky: a write was attempted while full.
uart_tx  output  1  serial line, idle high.

Behaviour:
- Reset: sampled on a rising clk edge while resetn=0. It is synchronous, so there is no asynchronous path. Results: uart_tx=1, busy=0, full=0, empty=1, level=0, overflow=0, FSM=IDLE, pointers=0, baud counter=0, bit index=0.
- Reset mid-frame: the frame is abandoned, uart_tx returns to 1 on the next edge, and queued bytes are discarded.
- FIFO write: the byte is enqueued on a wr_en edge when full=0. If wr_en=1 while full=1, the byte is dropped and overflow is set to 1 on that edge.
- overflow: stays set until an ovf_clr edge. If ovf_clr and an overflowing write occur on the same edge, the set wins.
- FIFO read: performed only by the serializer, on the IDLE→START transition.
- Simultaneous write and read on one edge: level is unchanged. This also applies when full=1, because a read frees a slot in the same edge, so the write is accepted and overflow is not set.
- Write to an empty FIFO: the byte is visible to the serializer on the next cycle, so there is one cycle of FIFO latency.
- Pointers wrap modulo FIFO_DEPTH. level is the registered occupancy, not pointer subtraction with an ambiguous full case.
- FSM states:
  - IDLE: uart_tx=1. If empty=0, pop the head into the shift register, clear the baud counter, and go to START.
  - START: uart_tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: uart_tx=shift[0] for CLKS_PER_BIT cycles per bit. At the end of each bit, shift right and increment the index. After bit 7 completes, go to STOP.
  - STOP: uart_tx=1 for CLKS_PER_BIT cycles, then go to IDLE.
- Frame timing: 10×CLKS_PER_BIT cycles per frame. The IDLE→START pop adds one cycle, so back-to-back frames are spaced 10×CLKS_PER_BIT+1 cycles apart.
- uart_tx is driven from a register, so it is glitch-free.
- Latency: the start bit appears on uart_tx 2 cycles after a wr_en edge into an empty FIFO with FSM=IDLE. That is 1 cycle for the FIFO write and 1 for the pop; uart_tx changes on the edge after the pop.
- busy=1 in START, DATA and STOP. The TX path is fully drained when empty=1 and busy=0.
- Baud counter: width $clog2(CLKS_PER_BIT). It counts 0..CLKS_PER_BIT-1 and a bit ends when the count equals CLKS_PER_BIT-1.

Decomposition:
- Shared package uart_pkg holds:
  - state encoding localparams: TX_IDLE=2'd0, TX_START=2'd1, TX_DATA=2'd2, TX_STOP=2'd3;
  - the CLKS_PER_BIT computation helper;
  - the 8N1 frame constants (DATA_BITS=8, STOP_BITS=1).
- The FIFO is a natural sub-module, sync_fifo, parameterized by WIDTH=8 and DEPTH. It provides the wr/rd strobes, full/empty/level and the write-read-while-full rule above. It is reusable later by the RX side.
- The serializer FSM stays in uart_tx_fifo.

Test Plan:
- Use CLKS_PER_BIT=4 (CLK_FREQ=460800, BAUD=115200). Reset, then write 0xA5 → start bit 2 cycles later. Line sequence is 0,1,0,1,0,0,1,0,1,1, each held 4 cycles; busy=1 for 40 cycles, then empty=1 and busy=0.
- Write 0x00, 0xFF, 0x55 on three consecutive cycles → level goes 1,2,3, then drops to 2 at the first pop. Three frames are decoded in order with 41-cycle start-to-start spacing.
- Fill with 16 writes while a frame is in progress → full=1 and level=16. A 17th write of 0x99 leaves overflow=1 and level=16, and 0x99 is never transmitted. Pulse ovf_clr → overflow=0.
- With full=1 and FSM=IDLE, assert wr_en on the pop edge → level stays 16 and overflow stays 0. The written byte is later transmitted last.
- Assert resetn=0 for one cycle during DATA bit 3 of 0xC3 with 4 bytes queued → next cycle uart_tx=1, busy=0, level=0, empty=1, and no further frames are transmitted.
- Write with no reset applied after power-up is not tested, because resetn is always asserted first. Hold resetn=0 for 10 cycles while wr_en=1 → after release, level=0 and uart_tx=1 throughout.
